// File: rtl/switch_whack_conditioner.sv
// -----------------------------------------------------------------------------
// switch_whack_conditioner
//
// Purpose:
//   Conditions the 16 raw board switches for the game core. Each switch is
//   synchronised, then debounced on a slow sample tick. Every accepted level
//   change produces a one-clock toggle pulse. Toggles collect in a pending
//   register and leave as an indexed "whack" stream, lowest index first.
//
//   After reset the block primes itself. For STABLE_SAMPLES ticks it copies
//   the synchronised switches straight into sw_stable and emits no toggles.
//   Switches that are already on at power-up therefore never look like presses.
//
// Handshake (whack stream):
//   whack_valid/whack_idx present the lowest pending index. A whack is consumed
//   at a rising clk edge where whack_valid && whack_ready. The consumer may hold
//   whack_ready high at any time. While whack_valid is high and whack_ready is
//   low, the index is held. The one exception is a newly pending lower index,
//   which may take its place.
//
// Ports:
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   sw           in   16  raw asynchronous switch inputs
//   sw_stable    out  16  debounced switch levels
//   toggle       out  16  one-clk pulse per switch whose sw_stable changed
//   whack_valid  out  1   a pending whack is presented
//   whack_idx    out  4   index of the presented whack (0 when empty)
//   whack_ready  in   1   consumer accepts the presented whack
//   cond_ready   out  1   high once priming is complete
//   drop_pulse   out  1   one-clk pulse: a toggle hit an already-pending index
//   drop_count   out  8   saturating count of dropped toggles
//   dbg_state_o  out  1   current FSM state (0 = PRIME, 1 = RUN)
// -----------------------------------------------------------------------------
module switch_whack_conditioner #(
    parameter int CLK_IN_FREQ_HZ = 100_000_000,
    parameter int SAMPLE_FREQ_HZ = 1_000,
    parameter int STABLE_SAMPLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw,
    output logic [15:0] sw_stable,
    output logic [15:0] toggle,
    output logic        whack_valid,
    output logic [3:0]  whack_idx,
    input  logic        whack_ready,
    output logic        cond_ready,
    output logic        drop_pulse,
    output logic [7:0]  drop_count,
    output logic        dbg_state_o
);

    localparam int TICK_DIV = CLK_IN_FREQ_HZ / SAMPLE_FREQ_HZ;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // STABLE_SAMPLES >= 2, so CNT_W is at least 1.
    localparam int CNT_W    = $clog2(STABLE_SAMPLES);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser. It is left unreset on purpose: it refills
    // within two clocks, well before the first sample tick.
    // ------------------------------------------------------------------
    logic [15:0] sync1_q;
    logic [15:0] sync2_q;

    always_ff @(posedge clk) begin
        sync1_q <= sw;
        sync2_q <= sync1_q;
    end

    // ------------------------------------------------------------------
    // Free-running sample tick divider.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Priming / debounce FSM. All of its outputs are registered.
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [CNT_W-1:0] prime_cnt_q;
    logic [CNT_W-1:0] cnt_q [16];
    logic [15:0]      stable_q;
    logic [15:0]      toggle_q;
    logic             cond_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PRIME;
            prime_cnt_q  <= '0;
            stable_q     <= '0;
            toggle_q     <= '0;
            cond_ready_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // toggle only ever pulses for the single clock of a tick.
            toggle_q <= '0;
            if (tick) begin
                case (state_q)
                    ST_PRIME: begin
                        // Take the live level as-is, so switches already on
                        // at reset release never produce a toggle.
                        stable_q <= sync2_q;
                        if (prime_cnt_q == CNT_W'(STABLE_SAMPLES - 1)) begin
                            state_q      <= ST_RUN;
                            cond_ready_q <= 1'b1;
                            prime_cnt_q  <= '0;
                        end else begin
                            prime_cnt_q <= prime_cnt_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        for (int i = 0; i < 16; i++) begin
                            if (sync2_q[i] == stable_q[i]) begin
                                cnt_q[i] <= '0;
                            end else if (cnt_q[i] == CNT_W'(STABLE_SAMPLES - 1)) begin
                                stable_q[i] <= sync2_q[i];
                                toggle_q[i] <= 1'b1;
                                cnt_q[i]    <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_PRIME;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending register, whack presentation and drop accounting.
    // ------------------------------------------------------------------
    logic [15:0] pending_q;
    logic [15:0] pending_d;
    logic [15:0] clr;
    logic [15:0] drop_vec;
    logic [4:0]  drop_num;
    logic [8:0]  drop_sum;
    logic [3:0]  idx_c;
    logic        drop_pulse_q;
    logic        drop_pulse_d;
    logic [7:0]  drop_count_q;
    logic [7:0]  drop_count_d;

    // Lowest set index wins. The loop runs downward so the last hit is the lowest.
    always_comb begin
        idx_c = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                idx_c = 4'(i);
            end
        end
    end

    always_comb begin
        clr = '0;
        if ((pending_q != '0) && whack_ready && (state_q == ST_RUN)) begin
            clr[idx_c] = 1'b1;
        end

        // A toggle on the index being accepted this clock re-arms that index.
        // It is not counted as a drop.
        drop_vec = toggle_q & pending_q & ~clr;

        drop_num = '0;
        for (int i = 0; i < 16; i++) begin
            drop_num = drop_num + {4'b0000, drop_vec[i]};
        end

        drop_sum     = {1'b0, drop_count_q} + {4'b0000, drop_num};
        drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        drop_pulse_d = (drop_vec != '0);
        pending_d    = (pending_q & ~clr) | toggle_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            pending_q    <= pending_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sw_stable   = stable_q;
    assign toggle      = toggle_q;
    assign whack_valid = (pending_q != '0);
    assign whack_idx   = idx_c;
    assign cond_ready  = cond_ready_q;
    assign drop_pulse  = drop_pulse_q;
    assign drop_count  = drop_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_switch_whack_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for switch_whack_conditioner.
// Parameters: 100 Hz clock and 25 Hz sample rate, so there is one tick every
// 4 clocks. STABLE_SAMPLES is 3.
// The reference model below works from the observable rules:
//   - synchronised sample = raw input two clocks earlier
//   - tick on every 4th clock after reset release
//   - a change is accepted when the last 3 tick samples all differ from the
//     stable level
//   - pending is a set drained lowest-first
// -----------------------------------------------------------------------------
module tb_switch_whack_conditioner;

    localparam int CLK_HZ = 100;
    localparam int SMP_HZ = 25;
    localparam int STABLE = 3;
    localparam int DIV    = CLK_HZ / SMP_HZ;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic        whack_ready;
    logic [15:0] sw_stable;
    logic [15:0] toggle;
    logic        whack_valid;
    logic [3:0]  whack_idx;
    logic        cond_ready;
    logic        drop_pulse;
    logic [7:0]  drop_count;
    logic        dbg_state;

    always #5 clk = ~clk;

    switch_whack_conditioner #(
        .CLK_IN_FREQ_HZ(CLK_HZ),
        .SAMPLE_FREQ_HZ(SMP_HZ),
        .STABLE_SAMPLES(STABLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .sw_stable  (sw_stable),
        .toggle     (toggle),
        .whack_valid(whack_valid),
        .whack_idx  (whack_idx),
        .whack_ready(whack_ready),
        .cond_ready (cond_ready),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count),
        .dbg_state_o(dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model state ----------------
    int          m_n;
    bit          m_run;
    int          m_prime_ticks;
    logic [15:0] m_stable;
    logic [15:0] m_toggle;
    logic [15:0] m_pending;
    int          m_drops;
    logic        m_drop_pulse;
    logic [15:0] m_hist [$];
    logic [15:0] m_win  [$];

    function automatic logic [3:0] lowest(input logic [15:0] p);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (p[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Called at every rising edge, with the inputs as they were sampled.
    task automatic model_edge();
        logic [15:0] s_used;
        logic [15:0] clr;
        logic [15:0] dropv;
        logic [15:0] acc;
        bit          all_diff;
        int          pc;
        s_used = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 16'h0000;
        m_hist.push_back(sw);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        if (reset) begin
            m_n = 0; m_run = 0; m_prime_ticks = 0;
            m_stable = '0; m_toggle = '0; m_pending = '0;
            m_drops = 0; m_drop_pulse = 1'b0;
            m_win.delete();
            return;
        end
        clr = '0;
        if (m_pending != 0 && whack_ready) clr[lowest(m_pending)] = 1'b1;
        dropv = m_toggle & m_pending & ~clr;
        pc = $countones(dropv);
        m_drop_pulse = (pc > 0);
        m_drops = (m_drops + pc > 255) ? 255 : m_drops + pc;
        m_pending = (m_pending & ~clr) | m_toggle;
        m_n++;
        acc = '0;
        if (m_n % DIV == 0) begin
            if (!m_run) begin
                m_stable = s_used;
                m_prime_ticks++;
                if (m_prime_ticks == STABLE) begin
                    m_run = 1;
                    m_win.delete();
                end
            end else begin
                m_win.push_back(s_used);
                if (m_win.size() > STABLE) void'(m_win.pop_front());
                if (m_win.size() == STABLE) begin
                    for (int b = 0; b < 16; b++) begin
                        all_diff = 1;
                        foreach (m_win[k]) begin
                            if (m_win[k][b] == m_stable[b]) all_diff = 0;
                        end
                        acc[b] = all_diff;
                    end
                end
                m_stable = m_stable ^ acc;
            end
        end
        m_toggle = acc;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sw_stable",   sw_stable,            m_stable);
        chk("toggle",      toggle,               m_toggle);
        chk("whack_valid", {15'd0, whack_valid}, {15'd0, (m_pending != 0)});
        chk("whack_idx",   {12'd0, whack_idx},   {12'd0, lowest(m_pending)});
        chk("cond_ready",  {15'd0, cond_ready},  {15'd0, m_run});
        chk("drop_pulse",  {15'd0, drop_pulse},  {15'd0, m_drop_pulse});
        chk("drop_count",  {8'd0, drop_count},   16'(m_drops));
        chk("dbg_state",   {15'd0, dbg_state},   {15'd0, m_run});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Step until the DUT raises any toggle bit. Expiry counts as a failure.
    task automatic wait_toggle(input string tag);
        int k;
        k = 0;
        while (toggle == 16'h0000 && k < 60) begin
            step();
            k++;
        end
        checks++;
        assert (k < 60) else begin
            failures++;
            $error("FAIL %s_timeout observed=no_toggle expected=toggle_within_60", tag);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b;
        reset       = 1'b1;
        sw          = 16'h0005;
        whack_ready = 1'b0;

        // 1: reset with 0005 held, then prime
        repeat (4) step();
        chk("rst_sw_stable",   sw_stable,            16'h0000);
        chk("rst_toggle",      toggle,               16'h0000);
        chk("rst_whack_valid", {15'd0, whack_valid}, 16'h0000);
        chk("rst_whack_idx",   {12'd0, whack_idx},   16'h0000);
        chk("rst_cond_ready",  {15'd0, cond_ready},  16'h0000);
        chk("rst_drop_count",  {8'd0, drop_count},   16'h0000);
        reset = 1'b0;
        repeat (11) step();
        chk("prime_not_ready", {15'd0, cond_ready},  16'h0000);
        step();
        chk("prime_ready",     {15'd0, cond_ready},  16'h0001);
        chk("prime_stable",    sw_stable,            16'h0005);
        chk("prime_no_whack",  {15'd0, whack_valid}, 16'h0000);

        // 2: sw[7] rises
        sw = 16'h0085;
        wait_toggle("t2");
        chk("t2_toggle",  toggle,                 16'h0080);
        chk("t2_stable7", {15'd0, sw_stable[7]},  16'h0001);
        step();
        chk("t2_valid",   {15'd0, whack_valid},   16'h0001);
        chk("t2_idx",     {12'd0, whack_idx},     16'h0007);
        whack_ready = 1'b1;
        step();
        whack_ready = 1'b0;
        chk("t2_drained", {15'd0, whack_valid},   16'h0000);

        // 3: glitch on sw[3] for two ticks
        sw = 16'h008D;
        repeat (8) step();
        sw = 16'h0085;
        repeat (30) step();
        chk("t3_stable", sw_stable,            16'h0085);
        chk("t3_valid",  {15'd0, whack_valid}, 16'h0000);

        // 4: three simultaneous flips, ascending drain
        sw = 16'h0085 ^ 16'h4204;
        wait_toggle("t4");
        chk("t4_toggle", toggle, 16'h4204);
        step();
        chk("t4_idx2", {12'd0, whack_idx}, 16'h0002);
        whack_ready = 1'b1;
        step();
        chk("t4_idx9", {12'd0, whack_idx}, 16'h0009);
        step();
        chk("t4_idx14", {12'd0, whack_idx}, 16'h000E);
        step();
        chk("t4_empty", {15'd0, whack_valid}, 16'h0000);
        whack_ready = 1'b0;

        // 5: drops on bit 5, then saturation using all-bit flips
        sw = sw ^ 16'h0020;
        wait_toggle("t5a");
        step();
        chk("t5_idx5", {12'd0, whack_idx}, 16'h0005);
        sw = sw ^ 16'h0020;
        wait_toggle("t5b");
        step();
        chk("t5_drop_pulse", {15'd0, drop_pulse}, 16'h0001);
        chk("t5_drop_count", {8'd0, drop_count},  16'h0001);
        step();
        chk("t5_drop_end",   {15'd0, drop_pulse}, 16'h0000);
        for (int r = 0; r < 17; r++) begin
            sw = ~sw;
            wait_toggle("t5_all");
            step();
        end
        chk("t5_saturated", {8'd0, drop_count}, 16'h00FF);
        whack_ready = 1'b1;
        repeat (18) step();
        whack_ready = 1'b0;
        chk("t5_drained", {15'd0, whack_valid}, 16'h0000);

        // 6: accept on bit 5 in the same clock its new toggle arrives
        sw = sw ^ 16'h0020;
        wait_toggle("t6a");
        step();
        sw = sw ^ 16'h0020;
        wait_toggle("t6b");
        whack_ready = 1'b1;
        step();
        whack_ready = 1'b0;
        chk("t6_no_drop", {15'd0, drop_pulse},  16'h0000);
        chk("t6_valid",   {15'd0, whack_valid}, 16'h0001);
        chk("t6_idx",     {12'd0, whack_idx},   16'h0005);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 11) == 0) begin
                b = $urandom_range(0, 15);
                sw[b] = ~sw[b];
            end
            whack_ready = ($urandom_range(0, 3) == 0);
            step();
        end

        // reset mid-stream with a whack pending
        whack_ready = 1'b0;
        sw = sw ^ 16'h0001;
        wait_toggle("t6c");
        step();
        chk("t6_pre_rst_valid", {15'd0, whack_valid}, 16'h0001);
        reset = 1'b1;
        step();
        chk("t6_rst_stable", sw_stable,            16'h0000);
        chk("t6_rst_toggle", toggle,               16'h0000);
        chk("t6_rst_valid",  {15'd0, whack_valid}, 16'h0000);
        chk("t6_rst_idx",    {12'd0, whack_idx},   16'h0000);
        chk("t6_rst_ready",  {15'd0, cond_ready},  16'h0000);
        chk("t6_rst_dcount", {8'd0, drop_count},   16'h0000);
        chk("t6_rst_state",  {15'd0, dbg_state},   16'h0000);
        reset = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
